// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - stall and forwarding-select control for the E/M/W stages; optional STALL_CNT_EN adds stall_cnt
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int T_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [T_W-1:0]    d_tuse_rs,
  input  logic [T_W-1:0]    d_tuse_rt,
  input  logic              d_wr,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [T_W-1:0]    d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_M    = 2'd1;
  localparam logic [1:0] SEL_W    = 2'd2;

  // E entry: the instruction currently executing, with its source indices for E-stage forwarding
  logic              e_vld;
  logic [REG_AW-1:0] e_dst;
  logic [T_W-1:0]    e_tnew;
  logic [REG_AW-1:0] e_rs;
  logic [REG_AW-1:0] e_rt;

  // M entry: tnew already counted down once
  logic              m_vld;
  logic [REG_AW-1:0] m_dst;
  logic [T_W-1:0]    m_tnew;

  // W entry: its result always exists, so no tnew is kept
  logic              w_vld;
  logic [REG_AW-1:0] w_dst;

  logic e_ld;

  // Saturating countdown of cycles until the result exists
  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Register 0 is hard-wired zero and never produces a dependency
  function automatic logic hit(input logic vld, input logic [REG_AW-1:0] dst,
                               input logic [REG_AW-1:0] src);
    return vld && (dst == src) && (src != '0);
  endfunction

  // Nearest producer wins: M only once its result exists, otherwise W
  function automatic logic [1:0] fwd_sel(input logic m_h, input logic m_rdy, input logic w_h);
    if (m_h && m_rdy) return SEL_M;
    if (w_h)          return SEL_W;
    return SEL_BASE;
  endfunction

  assign e_ld = d_valid && !stall;

  // Stall when a producer in E or M cannot deliver before the D instruction needs the value
  always_comb begin
    stall = 1'b0;
    if (d_valid) begin
      if (hit(e_vld, e_dst, d_rs) && (e_tnew > d_tuse_rs)) stall = 1'b1;
      if (hit(e_vld, e_dst, d_rt) && (e_tnew > d_tuse_rt)) stall = 1'b1;
      if (hit(m_vld, m_dst, d_rs) && (m_tnew > d_tuse_rs)) stall = 1'b1;
      if (hit(m_vld, m_dst, d_rt) && (m_tnew > d_tuse_rt)) stall = 1'b1;
    end
  end

  // Operand mux selects for D and E; E has no E-to-D path since tnew>=1 there
  always_comb begin
    fwd_d_rs = fwd_sel(hit(m_vld, m_dst, d_rs), m_tnew == '0, hit(w_vld, w_dst, d_rs));
    fwd_d_rt = fwd_sel(hit(m_vld, m_dst, d_rt), m_tnew == '0, hit(w_vld, w_dst, d_rt));
    fwd_e_rs = fwd_sel(hit(m_vld, m_dst, e_rs), m_tnew == '0, hit(w_vld, w_dst, e_rs));
    fwd_e_rt = fwd_sel(hit(m_vld, m_dst, e_rt), m_tnew == '0, hit(w_vld, w_dst, e_rt));
  end

  // Advance the in-flight write tracker; E takes a bubble on stall or an empty D slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld  <= 1'b0;
      e_dst  <= '0;
      e_tnew <= '0;
      e_rs   <= '0;
      e_rt   <= '0;
      m_vld  <= 1'b0;
      m_dst  <= '0;
      m_tnew <= '0;
      w_vld  <= 1'b0;
      w_dst  <= '0;
    end else begin
      w_vld  <= m_vld;
      w_dst  <= m_dst;
      m_vld  <= e_vld;
      m_dst  <= e_dst;
      m_tnew <= sat_dec(e_tnew);
      if (e_ld) begin
        e_vld  <= d_wr && (d_dst != '0);
        e_dst  <= d_dst;
        e_tnew <= d_tnew;
        e_rs   <= d_rs;
        e_rt   <= d_rt;
      end else begin
        e_vld  <= 1'b0;
        e_dst  <= '0;
        e_tnew <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
      end
    end
  end

`ifdef STALL_CNT_EN
  // Free-running count of stalled cycles, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
